// File: rtl/aes128_ctr_sequencer.sv
// CTR-mode sequencer around a shared AES-128 encrypt core: one block at a time,
// START pulses the core reset, WAIT collects the keystream, MIX/OUT stream data.
module aes128_ctr_sequencer #(
    parameter int CTR_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [127:0] cfg_key,
    input  logic [127:0] cfg_iv,
    input  logic [15:0]  cfg_nblocks,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [127:0] din_data,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [127:0] dout_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         core_reset_n,
    output logic [127:0] core_in,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    input  logic         core_ready
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [127:0] CTR_MASK =
        (CTR_WIDTH >= 128) ? {128{1'b1}} : ((128'd1 << CTR_WIDTH) - 128'd1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_MIX, S_OUT, S_FIN
    } state_t;

    state_t              r_state;
    logic [127:0]        r_key;
    logic [127:0]        r_ctr;
    logic [127:0]        r_ks;
    logic [127:0]        r_dout_data;
    logic [15:0]         r_remaining;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic                r_err;

    logic [127:0]        w_ctr_next;
    logic                w_last_block;

    // Only the low CTR_WIDTH bits count; a wrap never carries into the nonce part.
    assign w_ctr_next   = (r_ctr & ~CTR_MASK) | ((r_ctr + 128'd1) & CTR_MASK);
    assign w_last_block = (r_remaining == 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_key       <= '0;
            r_ctr       <= '0;
            r_ks        <= '0;
            r_dout_data <= '0;
            r_remaining <= '0;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_key       <= cfg_key;
                        r_ctr       <= cfg_iv;
                        r_remaining <= cfg_nblocks;
                        r_err       <= 1'b0;
                        r_state     <= (cfg_nblocks != 16'd0) ? S_START : S_FIN;
                    end
                end
                S_START: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_ready) begin
                        r_ks    <= core_out;
                        r_ctr   <= w_ctr_next;
                        r_state <= S_MIX;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        // Core never answered: abandon the rest of the job.
                        r_err   <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    end
                end
                S_MIX: begin
                    if (din_valid) begin
                        r_dout_data <= din_data ^ r_ks;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (dout_ready) begin
                        r_remaining <= r_remaining - 16'd1;
                        r_state     <= w_last_block ? S_FIN : S_START;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_FIN);
    assign din_ready    = (r_state == S_MIX);
    assign dout_valid   = (r_state == S_OUT);
    assign err          = r_err;
    // Held low by the sequencer reset too, so the core restarts with us.
    assign core_reset_n = ~reset & (r_state != S_START);
    assign core_in      = r_ctr;
    assign core_key     = r_key;
    assign dout_data    = r_dout_data;

endmodule

// File: tb/tb_aes128_ctr_sequencer.sv
// Bench for aes128_ctr_sequencer: a behavioural AES-128 core with random latency
// and a CTR-mode reference built from the counter rules and a software AES.
module tb_aes128_ctr_sequencer;

    localparam int CTR_WIDTH = 32;
    localparam int TIMEOUT   = 255;

    logic         clk;
    logic         reset;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [127:0] cfg_key;
    logic [127:0] cfg_iv;
    logic [15:0]  cfg_nblocks;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] din_data;
    logic         dout_valid;
    logic         dout_ready;
    logic [127:0] dout_data;
    logic         busy;
    logic         done;
    logic         err;
    logic         core_reset_n;
    logic [127:0] core_in;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic         core_ready;

    aes128_ctr_sequencer #(
        .CTR_WIDTH(CTR_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_key     (cfg_key),
        .cfg_iv      (cfg_iv),
        .cfg_nblocks (cfg_nblocks),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .din_data    (din_data),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_data   (dout_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .core_reset_n(core_reset_n),
        .core_in     (core_in),
        .core_key    (core_key),
        .core_out    (core_out),
        .core_ready  (core_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- software AES-128 ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, xb;
        for (int x = 0; x < 256; x++) begin
            xb = 8'(x);
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int b = 0; b < 16; b++) s[b] = sbox[s[b]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) u[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int b = 0; b < 16; b++) s[b] = u[b];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    // ---------------- behavioural core: random latency, garbage until ready ----------------
    bit           core_dead = 1'b0;
    bit           core_armed = 1'b0;
    int           core_cnt = 0;
    logic [127:0] core_lat_in, core_lat_key;

    initial begin
        core_ready = 1'b0;
        core_out   = '0;
    end

    always @(negedge clk) begin
        if (!core_reset_n) begin
            core_ready   = 1'b0;
            core_armed   = 1'b1;
            core_cnt     = int'($urandom_range(1, 6));
            core_lat_in  = core_in;
            core_lat_key = core_key;
            core_out     = {$urandom, $urandom, $urandom, $urandom};
        end else if (core_armed && !core_dead) begin
            if (core_cnt > 1) begin
                core_cnt--;
                core_out = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                core_out   = aes_enc(core_lat_key, core_lat_in);
                core_ready = 1'b1;
                core_armed = 1'b0;
            end
        end else if (!core_ready) begin
            core_out = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_cfg_ready"},    128'(cfg_ready),    128'd1);
        chk({pfx, "_core_reset_n"}, 128'(core_reset_n), 128'd0);
        chk({pfx, "_busy"},         128'(busy),         128'd0);
        chk({pfx, "_done"},         128'(done),         128'd0);
        chk({pfx, "_err"},          128'(err),          128'd0);
        chk({pfx, "_din_ready"},    128'(din_ready),    128'd0);
        chk({pfx, "_dout_valid"},   128'(dout_valid),   128'd0);
        chk({pfx, "_dout_data"},    dout_data,          128'd0);
        chk({pfx, "_core_in"},      core_in,            128'd0);
        chk({pfx, "_core_key"},     core_key,           128'd0);
    endtask

    // One CTR job: reference expectations first, then a cycle-by-cycle drive/observe loop.
    task automatic run_job(input logic [127:0] key, input logic [127:0] iv, input int n,
                           input bit zero_din, input bit dead, input int abort_blk,
                           input bit bp10, output logic [127:0] first_dout);
        logic [127:0] exp_in[$], exp_out[$], din_q[$];
        logic [127:0] ctr, d, prev_d;
        int           starts, outs, dins, last_start, vcnt, exp_starts, exp_outs;
        bit           hs_din, hs_dout, prev_v, prev_r, ended;
        starts = 0; outs = 0; dins = 0; last_start = 0; vcnt = 0;
        hs_din = 0; hs_dout = 0; prev_v = 0; prev_r = 0; ended = 0;
        prev_d = '0; first_dout = '0;
        for (int i = 0; i < n; i++) begin
            ctr = iv;
            ctr[CTR_WIDTH-1:0] = iv[CTR_WIDTH-1:0] + CTR_WIDTH'(i);
            d = zero_din ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
            exp_in.push_back(ctr);
            din_q.push_back(d);
            exp_out.push_back(d ^ aes_enc(key, ctr));
        end
        exp_starts = (n == 0) ? 0 : (dead ? 1 : n);
        exp_outs   = dead ? 0 : n;
        core_dead  = dead;

        @(negedge clk);
        chk("cfg_ready_idle", 128'(cfg_ready), 128'd1);
        cfg_valid = 1'b1; cfg_key = key; cfg_iv = iv; cfg_nblocks = 16'(n);

        for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
            @(negedge clk);
            if (hs_din) dins++;
            if (hs_dout) begin
                chk("dout_count", 128'(outs < n), 128'd1);
                if (outs < n) chk($sformatf("dout[%0d]", outs), prev_d, exp_out[outs]);
                if (outs == 0) first_dout = prev_d;
                outs++;
                vcnt = 0;
            end
            if (prev_v && !prev_r) begin
                chk("dout_hold_valid", 128'(dout_valid), 128'd1);
                chk("dout_hold_data", dout_data, prev_d);
            end
            if (cyc == 0) chk("err_clear_on_cfg", 128'(err), 128'd0);
            chk("busy_in_job", 128'(busy), 128'd1);
            chk("cfg_ready_in_job", 128'(cfg_ready), 128'd0);
            if (!core_reset_n) begin
                chk("start_count", 128'(starts < n), 128'd1);
                if (starts < n) begin
                    chk($sformatf("core_in[%0d]", starts), core_in, exp_in[starts]);
                    chk($sformatf("core_key[%0d]", starts), core_key, key);
                end
                last_start = cyc;
                starts++;
            end
            if (abort_blk != 0 && starts == abort_blk && cyc == last_start + 1) begin
                cfg_valid = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
                reset = 1'b1;
                #1;
                check_reset_outputs("abort");
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk("abort_no_done", 128'(done), 128'd0);
                end
                reset = 1'b0;
                #1;
                chk("abort_release_core_reset_n", 128'(core_reset_n), 128'd1);
                chk("abort_release_cfg_ready", 128'(cfg_ready), 128'd1);
                core_dead = 1'b0;
                return;
            end
            if (dout_valid) vcnt++;
            if (done) begin
                ended = 1'b1;
                chk("done_starts", 128'(starts), 128'(exp_starts));
                chk("done_outs", 128'(outs), 128'(exp_outs));
                chk("done_dins", 128'(dins), 128'(exp_outs));
                chk("done_err", 128'(err), 128'(dead));
                if (n == 0) chk("empty_fin_latency", 128'(cyc), 128'd0);
                if (dead && n != 0) chk("timeout_cycles", 128'(cyc - last_start), 128'(TIMEOUT + 1));
                cfg_valid = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
            end else begin
                cfg_valid   = ($urandom_range(0, 3) == 0);
                cfg_key     = {$urandom, $urandom, $urandom, $urandom};
                cfg_iv      = {$urandom, $urandom, $urandom, $urandom};
                cfg_nblocks = 16'($urandom);
                din_valid   = (dins < n) && ($urandom_range(0, 2) != 0);
                din_data    = (din_valid && dins < n) ? din_q[dins]
                                                      : {$urandom, $urandom, $urandom, $urandom};
                dout_ready  = bp10 ? (dout_valid && vcnt > 10) : ($urandom_range(0, 2) == 0);
            end
            hs_din  = din_valid && din_ready;
            hs_dout = dout_valid && dout_ready;
            prev_v  = dout_valid;
            prev_r  = dout_ready;
            prev_d  = dout_data;
        end

        if (!ended) begin
            chk("job_budget", 128'd0, 128'd1);
            cfg_valid = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            core_dead = 1'b0;
            return;
        end
        @(negedge clk);
        chk("post_done_cfg_ready", 128'(cfg_ready), 128'd1);
        chk("post_done_busy", 128'(busy), 128'd0);
        chk("post_done_single_pulse", 128'(done), 128'd0);
        chk("post_done_err_sticky", 128'(err), 128'(dead));
        core_dead = 1'b0;
    endtask

    initial begin
        logic [127:0] fd;
        init_sbox();
        reset = 1'b1;
        cfg_valid = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_nblocks = '0;
        din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        chk("release_core_reset_n", 128'(core_reset_n), 128'd1);
        @(negedge clk);
        chk("release_idle", 128'(busy), 128'd0);

        run_job(128'd0, 128'd0, 1, 1'b1, 1'b0, 0, 1'b0, fd);
        chk("kat_dout", fd, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        run_job({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, 32'hFFFF_FFFF}, 2, 1'b0, 1'b0, 0, 1'b0, fd);
        run_job({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 3, 1'b0, 1'b0, 0, 1'b1, fd);
        run_job({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 3, 1'b0, 1'b1, 0, 1'b0, fd);
        run_job({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 1'b0, 0, 1'b0, fd);
        run_job({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 4, 1'b0, 1'b0, 2, 1'b0, fd);
        run_job({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 3, 1'b0, 1'b0, 0, 1'b0, fd);
        run_job({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0, 0, 1'b0, fd);
        for (int j = 0; j < 4; j++)
            run_job({$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom},
                    int'($urandom_range(1, 5)), 1'b0, 1'b0, 0, 1'b0, fd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
